// File: rtl/float_pkg.sv
// Shared FP32 definitions for the multi-cycle float datapath blocks.
// Contents: FP32 field widths, exponent bias constants, the common
// IDLE/ZCHK/NORM/ROUND state type and a field-packing helper.
package float_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int FP_W   = 1 + EXP_W + FRAC_W;

  localparam logic [EXP_W-1:0] BIAS      = 8'd127;
  // Exponent of a 32-bit integer whose MSB is bit 31 (BIAS + 31).
  localparam logic [EXP_W-1:0] E_INT_MAX = 8'd158;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ZCHK  = 2'd1,
    ST_NORM  = 2'd2,
    ST_ROUND = 2'd3
  } fp_state_e;

  function automatic logic [FP_W-1:0] fp32_pack(input logic              s,
                                                input logic [EXP_W-1:0]  e,
                                                input logic [FRAC_W-1:0] f);
    return {s, e, f};
  endfunction

endpackage

// File: rtl/int_to_float_if.sv
// Request/response bundle of the integer-to-FP32 converter.
//   start   : request a conversion of ia (master -> slave)
//   ia      : signed 32-bit operand     (master -> slave)
//   busy    : conversion in progress    (slave -> master)
//   done    : one-cycle completion pulse (slave -> master)
//   oz      : packed FP32 result, held   (slave -> master)
//   inexact : result was rounded, held   (slave -> master)
interface int_to_float_if;
  import float_pkg::*;

  logic            start;
  logic [31:0]     ia;
  logic            busy;
  logic            done;
  logic [FP_W-1:0] oz;
  logic            inexact;

  modport master (output start, ia, input  busy, done, oz, inexact);
  modport slave  (input  start, ia, output busy, done, oz, inexact);

endinterface

// File: rtl/fp32_round_pack.sv
// Combinational round-to-nearest-even and FP32 packing.
//   i_sign    : result sign
//   i_exp     : biased exponent matching i_mag[31]
//   i_mag     : normalised magnitude, hidden bit in bit 31
//   o_word    : packed FP32 word {sign, exp, frac}
//   o_inexact : any discarded bit was set
// A magnitude with bit 31 clear can only be zero here and packs to a signed zero.
module fp32_round_pack
  import float_pkg::*;
(
  input  logic             i_sign,
  input  logic [EXP_W-1:0] i_exp,
  input  logic [31:0]      i_mag,
  output logic [FP_W-1:0]  o_word,
  output logic             o_inexact
);

  // Returns frac + round increment with one carry bit on top.
  function automatic logic [FRAC_W:0] rne_incr(input logic [31:0] mag);
    logic [FRAC_W-1:0] frac;
    logic              g;
    logic              st;
    logic              up;
    frac = mag[30:8];
    g    = mag[7];
    st   = |mag[6:0];
    up   = g & (st | frac[0]);
    return {1'b0, frac} + {{FRAC_W{1'b0}}, up};
  endfunction

  logic [FRAC_W:0]  w_sum;
  logic [EXP_W-1:0] w_exp;

  assign w_sum = rne_incr(i_mag);
  // Carry out of the fraction leaves w_sum[FRAC_W-1:0] all zero; bump exponent.
  assign w_exp = i_exp + {{(EXP_W-1){1'b0}}, w_sum[FRAC_W]};

  always_comb begin
    o_word    = fp32_pack(i_sign, w_exp, w_sum[FRAC_W-1:0]);
    o_inexact = |i_mag[7:0];
    if (!i_mag[31]) begin
      o_word    = fp32_pack(i_sign, '0, '0);
      o_inexact = 1'b0;
    end
  end

endmodule

// File: rtl/int_to_float.sv
// Multi-cycle signed 32-bit integer to FP32 converter.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (aborts a conversion, clears oz)
//   bus  : int_to_float_if slave (start/ia in, busy/done/oz/inexact out)
// Flow: IDLE captures sign/magnitude, ZCHK short-cuts zero, NORM shifts one
// bit per cycle until the MSB is set, ROUND applies RNE and packs.
module int_to_float
  import float_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  int_to_float_if.slave  bus
);

  fp_state_e        r_state,   w_state_nx;
  logic [31:0]      r_mag,     w_mag_nx;
  logic [EXP_W-1:0] r_e,       w_e_nx;
  logic             r_s,       w_s_nx;
  logic             r_busy,    w_busy_nx;
  logic             r_done,    w_done_nx;
  logic [FP_W-1:0]  r_oz,      w_oz_nx;
  logic             r_inexact, w_inexact_nx;

  logic signed [31:0] w_ia;
  logic [31:0]        w_ia_abs;
  logic [FP_W-1:0]    w_pack;
  logic               w_pack_inexact;

  // -2^31 negates to itself, which read as unsigned is the correct magnitude.
  assign w_ia     = bus.ia;
  assign w_ia_abs = w_ia[31] ? $unsigned(-w_ia) : $unsigned(w_ia);

  fp32_round_pack u_round_pack (
    .i_sign    (r_s),
    .i_exp     (r_e),
    .i_mag     (r_mag),
    .o_word    (w_pack),
    .o_inexact (w_pack_inexact)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_mag     <= '0;
      r_e       <= '0;
      r_s       <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_oz      <= '0;
      r_inexact <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_mag     <= w_mag_nx;
      r_e       <= w_e_nx;
      r_s       <= w_s_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
      r_oz      <= w_oz_nx;
      r_inexact <= w_inexact_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_mag_nx     = r_mag;
    w_e_nx       = r_e;
    w_s_nx       = r_s;
    w_busy_nx    = r_busy;
    w_done_nx    = 1'b0;
    w_oz_nx      = r_oz;
    w_inexact_nx = r_inexact;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_s_nx     = bus.ia[31];
          w_mag_nx   = w_ia_abs;
          w_e_nx     = E_INT_MAX;
          w_busy_nx  = 1'b1;
          w_state_nx = ST_ZCHK;
        end
      end
      ST_ZCHK: begin
        if (r_mag == '0) begin
          // Zero (of either input sign) always yields +0.
          w_oz_nx      = '0;
          w_inexact_nx = 1'b0;
          w_done_nx    = 1'b1;
          w_busy_nx    = 1'b0;
          w_state_nx   = ST_IDLE;
        end else begin
          w_state_nx = ST_NORM;
        end
      end
      ST_NORM: begin
        if (r_mag[31]) begin
          w_state_nx = ST_ROUND;
        end else begin
          w_mag_nx = r_mag << 1;
          w_e_nx   = r_e - 8'd1;
        end
      end
      ST_ROUND: begin
        w_oz_nx      = w_pack;
        w_inexact_nx = w_pack_inexact;
        w_done_nx    = 1'b1;
        w_busy_nx    = 1'b0;
        w_state_nx   = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.oz      = r_oz;
  assign bus.inexact = r_inexact;

endmodule

// File: tb/tb_int_to_float.sv
module tb_int_to_float;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  int_to_float_if bus ();

  int_to_float dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ia;
    logic [31:0] oz;
    logic        inx;
    int          lat;  // rising edges after the accepting edge until done is set
  } vec_t;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Reference: exact magnitude, find MSB, round the remainder against half an ulp.
  function automatic void ref_conv(input logic [31:0] a, output logic [31:0] z,
                                   output logic inx, output int lat);
    longint unsigned mag, q, rem, half;
    int p, sh, e;
    logic s;
    s   = a[31];
    mag = s ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
    if (mag == 0) begin
      z = 32'h0; inx = 1'b0; lat = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (((mag >> i) & 64'd1) != 0) p = i;
    lat = (31 - p) + 3;
    if (p <= 23) begin
      q   = mag << (23 - p);
      inx = 1'b0;
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && (q & 64'd1) != 0)) q = q + 1;
      inx = (rem != 0);
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    e = 127 + p;
    z = {s, 8'(e), 23'(q)};
  endfunction

  // Drives start now (caller keeps away from the rising edge), returns after done.
  task automatic do_conv(input logic [31:0] a, output logic [31:0] z,
                         output logic inx, output int lat);
    bit to;
    bus.start = 1'b1;
    bus.ia    = a;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.ia    = $urandom;
    chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    lat = 0;
    to  = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) begin
        to = 1'b0;
        break;
      end
    end
    chk("done_timeout", {31'd0, to}, 32'd0);
    chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
    z   = bus.oz;
    inx = bus.inexact;
  endtask

  vec_t        vecs[8];
  logic [31:0] z, ez, a;
  logic        inx, einx;
  int          lat, elat, dcnt;

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.ia    = '0;

    vecs[0] = '{32'h0000_0001, 32'h3F80_0000, 1'b0, 34};
    vecs[1] = '{32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 34};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1};
    vecs[3] = '{32'h8000_0000, 32'hCF00_0000, 1'b0, 3};
    vecs[4] = '{32'h7FFF_FFFF, 32'h4F00_0000, 1'b1, 4};
    vecs[5] = '{32'd16777217,  32'h4B80_0000, 1'b1, 10};
    vecs[6] = '{32'd16777219,  32'h4B80_0002, 1'b1, 10};
    vecs[7] = '{32'd16777216,  32'h4B80_0000, 1'b0, 10};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",    {31'd0, bus.busy},    32'd0);
    chk("rst_done",    {31'd0, bus.done},    32'd0);
    chk("rst_oz",      bus.oz,               32'd0);
    chk("rst_inexact", {31'd0, bus.inexact}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      @(negedge clk);
      do_conv(vecs[i].ia, z, inx, lat);
      chk($sformatf("vec%0d_oz", i),  z,              vecs[i].oz);
      chk($sformatf("vec%0d_inx", i), {31'd0, inx},   {31'd0, vecs[i].inx});
      chk($sformatf("vec%0d_lat", i), lat,            vecs[i].lat);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_width", i), {31'd0, bus.done}, 32'd0);
    end

    // start pulses while busy are ignored: exactly one done
    ref_conv(32'd5, ez, einx, elat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.ia    = 32'd5;
    @(posedge clk);
    dcnt = 0;
    z    = '0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      bus.start = (k == 3 || k == 7 || k == 20);
      bus.ia    = $urandom;
      @(posedge clk); #1;
      if (bus.done) begin
        dcnt++;
        z = bus.oz;
      end
    end
    bus.start = 1'b0;
    chk("ignore_start_done_count", dcnt, 1);
    chk("ignore_start_oz", z, ez);

    // Back-to-back: second start presented in the done cycle
    @(negedge clk);
    do_conv(32'd1000, z, inx, lat);
    ref_conv(32'd1000, ez, einx, elat);
    chk("b2b_first_oz", z, ez);
    a = 32'hFFFF_FC18;  // -1000
    do_conv(a, z, inx, lat);
    ref_conv(a, ez, einx, elat);
    chk("b2b_second_oz", z, ez);
    chk("b2b_second_lat", lat, elat);

    // Reset in the middle of NORM
    @(negedge clk);
    bus.start = 1'b1;
    bus.ia    = 32'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) dcnt++;
    end
    chk("rst_mid_no_done", dcnt, 0);
    chk("rst_mid_oz",      bus.oz, 32'd0);
    chk("rst_mid_busy",    {31'd0, bus.busy}, 32'd0);
    chk("rst_mid_inexact", {31'd0, bus.inexact}, 32'd0);
    @(negedge clk);
    do_conv(32'd1, z, inx, lat);
    chk("after_rst_oz",  z,   32'h3F80_0000);
    chk("after_rst_lat", lat, 34);

    // rst wins over start in the same cycle
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.ia    = 32'd7;
    @(posedge clk); #1;
    chk("rst_prio_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("rst_prio_busy_after", {31'd0, bus.busy}, 32'd0);

    // Randomised against the reference model
    for (int n = 0; n < 150; n++) begin
      a = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) a = -a;
      ref_conv(a, ez, einx, elat);
      @(negedge clk);
      do_conv(a, z, inx, lat);
      chk($sformatf("rnd_oz ia=%h", a),  z,            ez);
      chk($sformatf("rnd_inx ia=%h", a), {31'd0, inx}, {31'd0, einx});
      chk($sformatf("rnd_lat ia=%h", a), lat,          elat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
